car_mode_sel: RTL
=================

# car_mode_sel

Front-end stage for the tail-light controller. It synchronises and debounces the raw DIP-switch driving-mode input and a hazard push-button, and enforces a blank gap on direct left↔right reversals. It presents a clean, registered 4-bit mode code plus a change strobe. Its `mode` output drives the tail-light block's `sw` input directly, on the same `clk`/`rst` domain.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 120000: cycles an input must be stable before acceptance (20 ms at 6 MHz).
- GAP_CYCLES, 1500000: forced straight (0000) interval on a direct left↔right reversal (250 ms at 6 MHz).

Ports:
- clk  in  1  system clock, 6 MHz.
- rst  in  1  reset, asynchronous, active-low.
- sw_raw  in  4  raw DIP switches, asynchronous to clk.
- btn_hazard  in  1  raw hazard button, active-high, asynchronous, bouncy.
- mode  out  4  registered mode code: 0000 straight, 0001 left, 0010 right, 0011 stop/fault.
- mode_valid  out  1  high once the first debounced switch value has been accepted.
- mode_chg  out  1  one-cycle pulse in the cycle `mode` takes a new value.
- hazard_on  out  1  hazard latch state.

## Operation
- Synchronisation: two-flop synchroniser on each of `sw_raw[3:0]` and `btn_hazard`.
- Debounce (4-bit group and 1-bit button, each independent):
  - Hold a candidate register and a counter of width clog2(DEBOUNCE_CYCLES).
  - If the synced value differs from the candidate, load the candidate and clear the counter.
  - Otherwise count up. When the count reaches DEBOUNCE_CYCLES-1, copy the candidate to the stable output and saturate the counter.
- Hazard latch: each rising edge of the debounced button toggles `hazard_on`.
- Requested code (req):
  - If `hazard_on`, req = 0011.
  - Otherwise, if stable sw[3:2] != 00, req = 0011 (fail-safe on an illegal code).
  - Otherwise, req = {00, stable sw[1:0]}.
- FSM states: S_INIT, S_RUN, S_GAP.
  - S_INIT: `mode` = 0000, `mode_valid` = 0. Moves to S_RUN when the first switch debounce completes. On that transition, set `mode_valid` = 1 and `mode` = req.
  - S_RUN: if req == mode, hold. If req is a direct reversal (mode 0001 and req 0010, or the reverse), set `mode` = 0000, load the gap counter with GAP_CYCLES-1, and go to S_GAP. Any other differing req loads `mode` = req.
  - S_GAP: `mode` holds 0000 while the counter decrements.
    - If req becomes 0011, abort the gap immediately: `mode` = 0011, go to S_RUN.
    - If req becomes 0000, go to S_RUN.
    - At counter zero, `mode` = req, go to S_RUN.
- `mode_chg` pulses for exactly one cycle on every `mode` update, including S_INIT exit, the entry into the gap's 0000, and the gap exit. It does not pulse when `mode` is unchanged.
- Reset values: mode = 0000, mode_valid = 0, mode_chg = 0, hazard_on = 0. All counters, candidates and synchronisers clear to 0; FSM goes to S_INIT.

## Timing
- Switch latency: a `sw_raw` value held from edge 0 appears on `mode` after edge DEBOUNCE_CYCLES+3. This is 2 cycles of synchroniser, DEBOUNCE_CYCLES of stability, and 1 cycle of output register.
- Glitches shorter than DEBOUNCE_CYCLES cycles after synchronisation never reach `mode`.
- Hazard latency: `hazard_on` toggles DEBOUNCE_CYCLES+3 cycles after the button's clean rising edge. `mode` follows 1 cycle later.
- Simultaneous events: a hazard toggle and a switch change accepted in the same cycle are resolved by hazard priority.
- Asserting `rst` mid-gap or mid-debounce returns all state to reset values immediately. No pending value survives the reset.

## Structure
- Shared package `car_pkg`: mode constants MODE_STRAIGHT = 0000, MODE_LEFT = 0001, MODE_RIGHT = 0010, MODE_HAZARD = 0011. The tail-light block uses the same constants.
- One sub-module, `car_debounce`, parameterised by WIDTH and CYCLES and including its synchroniser. It is instantiated twice: WIDTH 4 for the switches and WIDTH 1 for the button.
- The FSM and hazard latch live in the top level.

## Test plan
(Run with DEBOUNCE_CYCLES = 8 and GAP_CYCLES = 16.)
- Reset, then hold `sw_raw` = 0001: `mode` = 0000 and `mode_valid` = 0 until edge 11. Then `mode` = 0001, `mode_valid` = 1, and `mode_chg` pulses once.
- From 0000, toggle `sw_raw` 0000↔0010 every 5 cycles for 100 cycles: `mode` stays 0000 and `mode_chg` never pulses.
- With `mode` = 0001, apply 0010: `mode` goes 0000 for 16 cycles, then 0010, with 2 `mode_chg` pulses.
- Mid-gap, press `btn_hazard` (clean, 20 cycles): `hazard_on` = 1, `mode` = 0011 immediately, gap aborted. A second press restores the switch code.
- Apply `sw_raw` = 0100: `mode` = 0011. Assert `rst` mid-debounce: all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/car_pkg.sv
// Shared mode codes and FSM state type for the car front-end and tail-light blocks.
package car_pkg;

    localparam logic [3:0] MODE_STRAIGHT = 4'b0000;
    localparam logic [3:0] MODE_LEFT     = 4'b0001;
    localparam logic [3:0] MODE_RIGHT    = 4'b0010;
    localparam logic [3:0] MODE_HAZARD   = 4'b0011;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } mode_state_t;

    // A direct left<->right swap needs a blank interval in between.
    function automatic logic is_reversal(input logic [3:0] cur, input logic [3:0] nxt);
        return ((cur == MODE_LEFT) && (nxt == MODE_RIGHT)) ||
               ((cur == MODE_RIGHT) && (nxt == MODE_LEFT));
    endfunction

endpackage

// File: rtl/car_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer for a WIDTH-bit group.
module car_debounce #(
    parameter int WIDTH  = 4,
    parameter int CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             vld
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

    logic [WIDTH-1:0] sync1, sync2, cand;
    logic [CW-1:0]    cnt;

    // Bring the asynchronous input into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Restart the count on any change; publish the candidate once it has held long enough.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand <= '0;
            cnt  <= '0;
            dout <= '0;
            vld  <= 1'b0;
        end else if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
        end else if (cnt == CNT_MAX) begin
            dout <= cand;
            vld  <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/car_mode_sel.sv
// Driving-mode front end: debounced switches and hazard button, reversal gap, registered mode code.
module car_mode_sel
    import car_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int GAP_CYCLES      = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_raw,
    input  logic       btn_hazard,
    output logic [3:0] mode,
    output logic       mode_valid,
    output logic       mode_chg,
    output logic       hazard_on
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);

    logic [3:0]  sw_stable;
    logic        sw_vld;
    logic        btn_stable, btn_vld, btn_q, btn_rise;
    logic [3:0]  req;
    logic [GW-1:0] gap_cnt;
    mode_state_t state;

    car_debounce #(.WIDTH(4), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk  (clk),
        .rst  (rst),
        .din  (sw_raw),
        .dout (sw_stable),
        .vld  (sw_vld)
    );

    car_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_hazard),
        .dout (btn_stable),
        .vld  (btn_vld)
    );

    assign btn_rise = btn_vld & btn_stable & ~btn_q;

    // Each debounced press toggles the hazard latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q     <= 1'b0;
            hazard_on <= 1'b0;
        end else begin
            btn_q <= btn_stable;
            if (btn_rise) hazard_on <= ~hazard_on;
        end
    end

    // Requested code: hazard wins, illegal upper switch bits fail safe to stop.
    always_comb begin
        req = MODE_STRAIGHT;
        if (hazard_on)                  req = MODE_HAZARD;
        else if (sw_stable[3:2] != 2'b00) req = MODE_HAZARD;
        else                            req = {2'b00, sw_stable[1:0]};
    end

    // Mode FSM: initial acceptance, run, and blank gap on left<->right reversal.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_INIT;
            mode       <= MODE_STRAIGHT;
            mode_valid <= 1'b0;
            mode_chg   <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            mode_chg <= 1'b0;
            case (state)
                S_INIT: begin
                    // First acceptance always strobes so downstream sees mode become valid.
                    if (sw_vld) begin
                        mode       <= req;
                        mode_valid <= 1'b1;
                        mode_chg   <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (req != mode) begin
                        mode_chg <= 1'b1;
                        if (is_reversal(mode, req)) begin
                            mode    <= MODE_STRAIGHT;
                            gap_cnt <= GAP_MAX;
                            state   <= S_GAP;
                        end else begin
                            mode <= req;
                        end
                    end
                end
                S_GAP: begin
                    if (req == MODE_HAZARD) begin
                        mode     <= MODE_HAZARD;
                        mode_chg <= 1'b1;
                        state    <= S_RUN;
                    end else if (req == MODE_STRAIGHT) begin
                        // Already showing straight, so no strobe.
                        state <= S_RUN;
                    end else if (gap_cnt == '0) begin
                        mode     <= req;
                        mode_chg <= 1'b1;
                        state    <= S_RUN;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule
